// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - ID/EX-side bundle of the forwarding and hazard unit
// master drives the ID-stage fields, slave is the hazard unit itself.
interface fwd_hazard_unit_if #(
   parameter int AW = 5,
   parameter int FW = 2
);
   logic          id_valid;
   logic [AW-1:0] id_rs;
   logic [AW-1:0] id_rt;
   logic          id_uses_rs;
   logic          id_uses_rt;
   logic [AW-1:0] id_dest;
   logic          id_regwrite;
   logic          id_isload;
   logic          ex_flush;
   logic          stall_id;
   logic [FW-1:0] fwd_a;
   logic [FW-1:0] fwd_b;
   logic          ex_valid;
   logic [31:0]   stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_dest, id_regwrite, id_isload, ex_flush,
      input  stall_id, fwd_a, fwd_b, ex_valid, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
             id_dest, id_regwrite, id_isload, ex_flush,
      output stall_id, fwd_a, fwd_b, ex_valid, stall_count
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX operand forwarding selects and ID load-use stall
// Optional stall statistics counter enabled by FWD_HAZARD_STATS_EN.
module fwd_hazard_unit #(
   parameter int AW         = 5,
   parameter int NUM_STAGES = 2,
   parameter int LOAD_READY = 2,
   parameter int FW         = 2
) (
   input  logic             clk,
   input  logic             rst,
   fwd_hazard_unit_if.slave bus
);
   localparam int NS = NUM_STAGES;

   if (NUM_STAGES < 1 || NUM_STAGES > 7) begin : g_bad_num_stages
      $error("fwd_hazard_unit: NUM_STAGES must be in 1..7");
   end
   if (LOAD_READY < 1 || LOAD_READY > NUM_STAGES) begin : g_bad_load_ready
      $error("fwd_hazard_unit: LOAD_READY must be in 1..NUM_STAGES");
   end
   if (FW < $clog2(NUM_STAGES + 1)) begin : g_bad_fw
      $error("fwd_hazard_unit: FW too narrow for NUM_STAGES");
   end

   // Slot 0 is EX; slot k (k >= 1) is the k-th stage after EX.
   logic [NS:0]         slot_valid_q,    slot_valid_d;
   logic [NS:0]         slot_regwrite_q, slot_regwrite_d;
   logic [NS:0]         slot_isload_q,   slot_isload_d;
   logic [NS:0][AW-1:0] slot_dest_q,     slot_dest_d;

   logic [AW-1:0] ex_rs_q,      ex_rs_d;
   logic [AW-1:0] ex_rt_q,      ex_rt_d;
   logic          ex_uses_rs_q, ex_uses_rs_d;
   logic          ex_uses_rt_q, ex_uses_rt_d;

   logic          stall_c;
   logic          take_id;
   logic          load_hit_a;
   logic          load_hit_b;
   logic [FW-1:0] fwd_a_c;
   logic [FW-1:0] fwd_b_c;

   function automatic logic producer_hit(
      input logic          v,
      input logic          rw,
      input logic [AW-1:0] dest,
      input logic [AW-1:0] src
   );
      return v && rw && (dest != '0) && (dest == src);
   endfunction

   // Youngest matching producer decides; a younger non-load shadows an older load.
   always_comb begin
      load_hit_a = 1'b0;
      load_hit_b = 1'b0;
      for (int j = NS; j >= 0; j--) begin
         if (producer_hit(slot_valid_q[j], slot_regwrite_q[j], slot_dest_q[j], bus.id_rs))
            load_hit_a = slot_isload_q[j] && ((j + 1) < LOAD_READY);
         if (producer_hit(slot_valid_q[j], slot_regwrite_q[j], slot_dest_q[j], bus.id_rt))
            load_hit_b = slot_isload_q[j] && ((j + 1) < LOAD_READY);
      end
      stall_c = !rst && bus.id_valid &&
                ((bus.id_uses_rs && load_hit_a) || (bus.id_uses_rt && load_hit_b));
   end

   always_comb begin
      fwd_a_c = '0;
      fwd_b_c = '0;
      for (int k = NS; k >= 1; k--) begin
         if (producer_hit(slot_valid_q[k], slot_regwrite_q[k], slot_dest_q[k], ex_rs_q))
            fwd_a_c = FW'(k);
         if (producer_hit(slot_valid_q[k], slot_regwrite_q[k], slot_dest_q[k], ex_rt_q))
            fwd_b_c = FW'(k);
      end
      if (!slot_valid_q[0] || !ex_uses_rs_q)
         fwd_a_c = '0;
      if (!slot_valid_q[0] || !ex_uses_rt_q)
         fwd_b_c = '0;
   end

   always_comb begin
      take_id         = bus.id_valid && !bus.ex_flush && !stall_c;
      slot_valid_d    = {slot_valid_q[NS-1:0],    take_id};
      slot_regwrite_d = {slot_regwrite_q[NS-1:0], take_id && bus.id_regwrite};
      slot_isload_d   = {slot_isload_q[NS-1:0],   take_id && bus.id_isload};
      slot_dest_d     = {slot_dest_q[NS-1:0],     take_id ? bus.id_dest : {AW{1'b0}}};
      ex_rs_d         = take_id ? bus.id_rs : '0;
      ex_rt_d         = take_id ? bus.id_rt : '0;
      ex_uses_rs_d    = take_id && bus.id_uses_rs;
      ex_uses_rt_d    = take_id && bus.id_uses_rt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_valid_q    <= '0;
         slot_regwrite_q <= '0;
         slot_isload_q   <= '0;
         slot_dest_q     <= '0;
         ex_rs_q         <= '0;
         ex_rt_q         <= '0;
         ex_uses_rs_q    <= 1'b0;
         ex_uses_rt_q    <= 1'b0;
      end else begin
         slot_valid_q    <= slot_valid_d;
         slot_regwrite_q <= slot_regwrite_d;
         slot_isload_q   <= slot_isload_d;
         slot_dest_q     <= slot_dest_d;
         ex_rs_q         <= ex_rs_d;
         ex_rt_q         <= ex_rt_d;
         ex_uses_rs_q    <= ex_uses_rs_d;
         ex_uses_rt_q    <= ex_uses_rt_d;
      end
   end

   assign bus.stall_id = stall_c;
   assign bus.fwd_a    = fwd_a_c;
   assign bus.fwd_b    = fwd_b_c;
   assign bus.ex_valid = slot_valid_q[0];

`ifdef FWD_HAZARD_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign bus.stall_count = stall_cnt_q;
`else
   assign bus.stall_count = 32'd0;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard bench for fwd_hazard_unit
// Unit 0 uses default parameters, unit 1 uses NUM_STAGES=3, LOAD_READY=3.
module tb_fwd_hazard_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fwd_hazard_unit_if #(.AW(5), .FW(2)) bus0 ();
   fwd_hazard_unit_if #(.AW(5), .FW(2)) bus1 ();

   fwd_hazard_unit #(.AW(5), .NUM_STAGES(2), .LOAD_READY(2), .FW(2)) u0 (
      .clk(clk), .rst(rst), .bus(bus0)
   );
   fwd_hazard_unit #(.AW(5), .NUM_STAGES(3), .LOAD_READY(3), .FW(2)) u1 (
      .clk(clk), .rst(rst), .bus(bus1)
   );

   typedef struct packed {
      logic       valid;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic [4:0] dest;
      logic       rw;
      logic       ld;
   } ins_t;

   typedef struct {
      int          sel;
      logic        stall;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        exv;
      logic [31:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          step_no = 0;
   logic [31:0] exp_cnt[2];
   localparam ins_t NOP = '0;

   function automatic ins_t mk(logic [4:0] rs, logic urs, logic [4:0] rt, logic urt,
                               logic [4:0] dest, logic rw, logic ld);
      ins_t i;
      i = '{valid: 1'b1, rs: rs, rt: rt, urs: urs, urt: urt, dest: dest, rw: rw, ld: ld};
      return i;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive(int sel, ins_t i, logic flush);
      ins_t z;
      ins_t a;
      ins_t b;
      z = '0;
      a = (sel == 0) ? i : z;
      b = (sel == 1) ? i : z;
      bus0.id_valid = a.valid; bus0.id_rs = a.rs; bus0.id_rt = a.rt;
      bus0.id_uses_rs = a.urs; bus0.id_uses_rt = a.urt; bus0.id_dest = a.dest;
      bus0.id_regwrite = a.rw; bus0.id_isload = a.ld;
      bus0.ex_flush = (sel == 0) ? flush : 1'b0;
      bus1.id_valid = b.valid; bus1.id_rs = b.rs; bus1.id_rt = b.rt;
      bus1.id_uses_rs = b.urs; bus1.id_uses_rt = b.urt; bus1.id_dest = b.dest;
      bus1.id_regwrite = b.rw; bus1.id_isload = b.ld;
      bus1.ex_flush = (sel == 1) ? flush : 1'b0;
   endtask

   task automatic push_exp(int sel, logic st, logic [1:0] fa, logic [1:0] fb, logic exv);
      exp_t e;
      e.sel = sel; e.stall = st; e.fa = fa; e.fb = fb; e.exv = exv;
`ifdef FWD_HAZARD_STATS_EN
      e.cnt = exp_cnt[sel];
`else
      e.cnt = 32'd0;
`endif
      exp_q.push_back(e);
   endtask

   task automatic compare_one();
      exp_t e;
      string t;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      t = $sformatf("u%0d.%0d", e.sel, step_no);
      if (e.sel == 0) begin
         check({t, " stall_id"},    32'(bus0.stall_id),  32'(e.stall));
         check({t, " fwd_a"},       32'(bus0.fwd_a),     32'(e.fa));
         check({t, " fwd_b"},       32'(bus0.fwd_b),     32'(e.fb));
         check({t, " ex_valid"},    32'(bus0.ex_valid),  32'(e.exv));
         check({t, " stall_count"}, bus0.stall_count,    e.cnt);
      end else begin
         check({t, " stall_id"},    32'(bus1.stall_id),  32'(e.stall));
         check({t, " fwd_a"},       32'(bus1.fwd_a),     32'(e.fa));
         check({t, " fwd_b"},       32'(bus1.fwd_b),     32'(e.fb));
         check({t, " ex_valid"},    32'(bus1.ex_valid),  32'(e.exv));
         check({t, " stall_count"}, bus1.stall_count,    e.cnt);
      end
   endtask

   // Drive one ID cycle at the falling edge, then compare the combinational outputs.
   task automatic step(int sel, ins_t i, logic flush, logic st,
                       logic [1:0] fa, logic [1:0] fb, logic exv);
      @(negedge clk);
      step_no++;
      drive(sel, i, flush);
      push_exp(sel, st, fa, fb, exv);
      #2;
      compare_one();
      if (st) exp_cnt[sel] = exp_cnt[sel] + 32'd1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      ins_t c;
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      drive(0, NOP, 1'b0);
      #2;
      push_exp(0, 0, 0, 0, 0); compare_one();
      push_exp(1, 0, 0, 0, 0); compare_one();
      @(negedge clk);
      rst = 1'b0;

      // Non-load producer forwarded from MEM.
      step(0, mk(1, 1, 2, 1, 9, 1, 0),  0, 0, 0, 0, 0);
      step(0, mk(9, 1, 4, 1, 3, 1, 0),  0, 0, 0, 0, 1);
      step(0, NOP,                      0, 0, 1, 0, 1);
      step(0, NOP,                      0, 0, 0, 0, 0);
      // Load-use on rt: one stall, bubble, then forward from WB.
      step(0, mk(1, 1, 0, 0, 11, 1, 1), 0, 0, 0, 0, 0);
      c = mk(6, 1, 11, 1, 12, 1, 0);
      step(0, c,                        0, 1, 0, 0, 1);
      step(0, c,                        0, 0, 0, 0, 0);
      step(0, NOP,                      0, 0, 0, 2, 1);
      step(0, NOP,                      0, 0, 0, 0, 0);
      // Two writers of $9: youngest wins.
      step(0, mk(1, 1, 2, 1, 9, 1, 0),  0, 0, 0, 0, 0);
      step(0, mk(1, 1, 2, 1, 9, 1, 0),  0, 0, 0, 0, 1);
      step(0, mk(9, 1, 13, 1, 14, 1, 0), 0, 0, 0, 0, 1);
      step(0, NOP,                      0, 0, 1, 0, 1);
      step(0, NOP,                      0, 0, 0, 0, 0);
      // Writers (one a load) of $0 never forward or stall.
      step(0, mk(1, 1, 2, 1, 0, 1, 0),  0, 0, 0, 0, 0);
      step(0, mk(1, 1, 2, 1, 0, 1, 1),  0, 0, 0, 0, 1);
      step(0, mk(0, 1, 15, 1, 16, 1, 0), 0, 0, 0, 0, 1);
      step(0, NOP,                      0, 0, 0, 0, 1);
      step(0, NOP,                      0, 0, 0, 0, 0);
      // Unused rt does not stall or forward.
      step(0, mk(1, 1, 0, 0, 5, 1, 1),  0, 0, 0, 0, 0);
      step(0, mk(17, 1, 5, 0, 18, 1, 0), 0, 0, 0, 0, 1);
      step(0, NOP,                      0, 0, 0, 0, 1);
      step(0, NOP,                      0, 0, 0, 0, 0);
      // Flush during a stall, then flush of a clean instruction.
      step(0, mk(1, 1, 0, 0, 20, 1, 1), 0, 0, 0, 0, 0);
      c = mk(20, 1, 21, 1, 22, 1, 0);
      step(0, c,                        1, 1, 0, 0, 1);
      step(0, c,                        0, 0, 0, 0, 0);
      step(0, NOP,                      0, 0, 2, 0, 1);
      step(0, mk(1, 1, 2, 1, 23, 1, 0), 1, 0, 0, 0, 0);
      step(0, NOP,                      0, 0, 0, 0, 0);
      // Third load-use pair, both operands dependent.
      step(0, mk(1, 1, 0, 0, 24, 1, 1), 0, 0, 0, 0, 0);
      c = mk(24, 1, 24, 1, 25, 1, 0);
      step(0, c,                        0, 1, 0, 0, 1);
      step(0, c,                        0, 0, 0, 0, 0);
      step(0, NOP,                      0, 0, 2, 2, 1);
      step(0, NOP,                      0, 0, 0, 0, 0);

      // Deeper pipeline: two stall cycles, then forward from stage 3.
      step(1, mk(1, 1, 0, 0, 7, 1, 1),  0, 0, 0, 0, 0);
      c = mk(7, 1, 2, 1, 8, 1, 0);
      step(1, c,                        0, 1, 0, 0, 1);
      step(1, c,                        0, 1, 0, 0, 0);
      step(1, c,                        0, 0, 0, 0, 0);
      step(1, NOP,                      0, 0, 3, 0, 1);
      step(1, NOP,                      0, 0, 0, 0, 0);
      // Asynchronous reset in the middle of a stall.
      step(1, mk(1, 1, 0, 0, 26, 1, 1), 0, 0, 0, 0, 0);
      step(1, mk(26, 1, 3, 1, 27, 1, 0), 0, 1, 0, 0, 1);
      #1;
      rst = 1'b1;
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      #1;
      step_no++;
      push_exp(1, 0, 0, 0, 0); compare_one();
      push_exp(0, 0, 0, 0, 0); compare_one();
      @(negedge clk);
      rst = 1'b0;
      drive(1, NOP, 1'b0);
      step(1, NOP,                      0, 0, 0, 0, 0);

      if (exp_q.size() != 0) check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the combinational EX-stage forwarding unit.
- Tracks destination registers of in-flight instructions internally in a shift pipeline of stage slots (EX, MEM, WB, ...), so it no longer takes per-stage writeReg/regWrite inputs.
- Produces per-operand forwarding selects for the EX stage.
- Produces a load-use stall request for the ID stage.
- Sits between the decode stage and the EX operand muxes of the MIPS pipeline.

Parameters:
- AW, 5: register address width.
- NUM_STAGES, 2: number of tracked stages after EX that have forwarding paths (1 = MEM, 2 = WB, ...). Legal range 1..7.
- LOAD_READY, 2: smallest post-EX stage index whose result mux carries load data. Legal range 1..NUM_STAGES.
- FW, 2: select width; must be at least clog2(NUM_STAGES+1). Checked by an elaboration-time assertion.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-high reset.
- id_valid, input, 1: ID holds a real instruction.
- id_rs, input, AW: ID source A register.
- id_rt, input, AW: ID source B register.
- id_uses_rs, input, 1: source A is actually read.
- id_uses_rt, input, 1: source B is actually read.
- id_dest, input, AW: ID destination register.
- id_regwrite, input, 1: ID instruction writes the register file.
- id_isload, input, 1: ID instruction is a load.
- ex_flush, input, 1: squash the instruction entering EX on the next edge.
- stall_id, output, 1: hold IF/ID this cycle (combinational).
- fwd_a, output, FW: EX operand A select.
- fwd_b, output, FW: EX operand B select.
- ex_valid, output, 1: EX slot holds a real instruction.
- stall_count, output, 32: stall statistics (see Optional Feature).

Behaviour:
- State:
  - Slot 0 = EX, slots 1..NUM_STAGES = post-EX stages.
  - Each slot holds {valid, dest, regwrite, isload}.
  - Slot 0 additionally holds {rs, rt, uses_rs, uses_rt}.
- Reset (async, rst=1): all slots cleared to invalid/zero; stall_id=0, fwd_a=fwd_b=0, ex_valid=0, stall_count=0. Reset mid-stall drops the stall immediately.
- Every rising clk edge (pipeline always advances downstream):
  - slot k+1 <= slot k for k = 0..NUM_STAGES-1; the oldest slot is discarded.
  - slot 0 <= bubble (all zero) if ex_flush or stall_id or !id_valid; otherwise slot 0 <= ID fields.
  - ex_flush has priority over everything; flush + stall together still gives a bubble.
- Producer match for slot j: valid & regwrite & dest != 0 & dest == src.
  - Register 0 is never matched, forwarded or stalled on.
- Forwarding (combinational from registered state, valid during the EX cycle):
  - fwd_a = smallest k in 1..NUM_STAGES whose slot k matches slot0.rs and slot0.uses_rs; 0 if none or slot 0 invalid.
  - fwd_b is identical, using rt/uses_rt.
  - Youngest producer wins. Example: MEM and WB both writing $9 gives select 1.
  - Encoding: 0 = register file, k = forward from post-EX stage k. This is a binary index and does not match the old one-hot-ish 10/01 encoding.
- Load-use stall (combinational):
  - For each used ID source, find the youngest matching slot j in 0..NUM_STAGES.
  - stall_id=1 if that slot has isload=1 and j+1 < LOAD_READY, and id_valid=1.
  - An older matching load is ignored if a younger non-load producer shadows it.
  - A producer past slot NUM_STAGES is taken to be in the register file, which writes before it reads.
- Default cycle behaviour (NUM_STAGES=2, LOAD_READY=2):
  - Load in EX with a dependent instruction in ID gives exactly 1 stall cycle; the bubble then enters EX.
  - The next cycle the load is in slot 1, j+1=2 is not below 2, so no stall; in EX that instruction sees fwd=2 (WB).
- Stall is purely a function of current inputs and state; there is no internal stall FSM beyond the slot pipeline.

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- Defined:
  - stall_count increments on every edge where stall_id=1 and rst=0.
  - It saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined:
  - stall_count is tied to 0 and no counter flops exist.
  - The port list is unchanged.

Test Plan:
- Default params; EX slot writes $9 (instruction in MEM next cycle), dependent add rs=$9 issues one cycle later -> in EX fwd_a=1, fwd_b=0, stall_id never 1.
- Load $11 in ID, next-cycle ID reads rt=$11 -> stall_id=1 for exactly 1 cycle; ex_valid=0 the following cycle; when the consumer reaches EX, fwd_b=2.
- Add $9 then sub $9 back-to-back, then consumer rs=$9 -> fwd_a=1 (youngest). Same sequence with dest=$0 -> fwd_a=0 and no stall.
- Load $5 in ID with id_uses_rt=0 on the consumer reading rt=$5 -> stall_id=0. ex_flush=1 while stall_id=1 -> bubble enters EX, ex_valid=0.
- NUM_STAGES=3, LOAD_READY=3: load $7 followed immediately by a $7 consumer -> 2 stall cycles, then fwd=3. Assert rst mid-stall -> stall_id=0 and all outputs 0 asynchronously.
- FWD_HAZARD_STATS_EN defined: three load-use pairs -> stall_count=3. Undefined: stall_count=0 throughout.
